merge_out_packer: RTL
=====================

MERGE_OUT_PACKER -- requirements
Module: merge_out_packer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 128, record width in bits; a record whose bits are all zero is the terminal (end-of-run) record.
REQ-002 SHALL use one clock; reset is asynchronous and active-low.
REQ-003 i_clk  in  1  rising-edge clock.
REQ-004 i_rst_n  in  1  asynchronous active-low reset.
REQ-005 i_data  in  8*DATA_WIDTH  8-record beat from the 8-wide merger; record k is bits [DATA_WIDTH*(k+1)-1 : DATA_WIDTH*k].
REQ-006 i_write  in  1  beat valid; driven by the merger's out-fifo-write strobe.
REQ-007 o_ready  out  1  packer accepts a beat this cycle; feeds the merger's out-ready input.
REQ-008 o_data  out  4*DATA_WIDTH  4-record output beat to the memory writer.
REQ-009 o_valid  out  1  o_data is valid.
REQ-010 i_ready  in  1  memory writer accepts o_data this cycle.
REQ-011 o_run_done  out  1  one-cycle pulse after a terminal record is transferred on the output.
REQ-012 o_overflow  out  1  sticky; set when i_write arrives while o_ready is low.
REQ-013 o_rec_count  out  32  non-terminal records transferred in the current run.
REQ-014 o_stall_count  out  32  cycles with o_valid=1 and i_ready=0.

Function
REQ-015 SHALL buffer input beats in a 2-entry FIFO of 8-record entries with an occupancy count of 0..2.
REQ-016 SHALL drive o_valid=1 whenever occupancy is nonzero.
REQ-017 SHALL hold a half pointer: half=0 presents head records 0..3 on o_data, half=1 presents head records 4..7.
REQ-018 An output transfer (o_valid & i_ready) SHALL toggle half; a transfer with half=1 SHALL pop the head entry.
REQ-019 o_ready SHALL be (occupancy<2) | pop, so a full FIFO accepts a beat in the same cycle the head is popped.
REQ-020 A push (i_write & o_ready) and a pop in the same cycle SHALL leave occupancy unchanged and keep data order.
REQ-021 Latency: a beat pushed at cycle t SHALL appear on o_data at t+1 if the FIFO was empty, records 0..3 first.
REQ-022 When i_write=1 and o_ready=0, SHALL drop the beat, leave state unchanged and set o_overflow until reset.
REQ-023 When an output transfer contains a terminal record at any position, SHALL pulse o_run_done on the next cycle.
REQ-024 On each output transfer, SHALL add the number of non-terminal records (0..4) to o_rec_count; the cycle o_run_done pulses, SHALL clear o_rec_count to 0 instead.
REQ-025 SHALL increment o_stall_count on each stall cycle.
REQ-026 Both counters SHALL saturate at 0xFFFFFFFF.
REQ-027 o_data SHALL be stable while o_valid=1 and i_ready=0.

Reset
REQ-028 i_rst_n low SHALL immediately clear occupancy, half, pointers, o_run_done, o_overflow and both counters; o_valid=0 and o_ready=1.
REQ-029 Reset asserted mid-beat SHALL discard buffered data, with no partial half emitted after release.
REQ-030 Buffer data storage need not be reset.

Configuration
REQ-031 Macro OUT_PACKER_STATS_EN: when defined, o_rec_count and o_stall_count SHALL behave per REQ-024..026.
REQ-032 When OUT_PACKER_STATS_EN is undefined, both ports SHALL remain present and tied to 0, and no counter logic SHALL be built; o_run_done and o_overflow are unaffected.

Verification
REQ-033 One beat with records 1..8, i_ready=1 -> o_data records 1..4 at t+1 and 5..8 at t+2; o_valid low at t+3; o_rec_count=8.
REQ-034 i_ready=0 while three beats are offered back-to-back -> beats 1 and 2 accepted, o_ready=0 on the 3rd, o_overflow=1, and o_stall_count increments every cycle.
REQ-035 FIFO full, i_ready=1 with half=1, and i_write the same cycle -> beat accepted, occupancy stays 2, and output order is preserved.
REQ-036 Beat with records 9,10,11,0,... -> o_run_done pulses once one cycle after the first half transfers, and o_rec_count reads 0 on that cycle.
REQ-037 i_rst_n pulsed low during an i_ready=0 stall with 2 entries buffered -> o_valid=0 asynchronously, counters 0, and no stale data after release.
REQ-038 Build without OUT_PACKER_STATS_EN and rerun REQ-033 -> identical o_data, and o_rec_count=o_stall_count=0 throughout.

Source files
------------

// File: rtl/merge_out_packer.sv
// 8-record to 4-record output packer behind the merger, 2-entry beat FIFO.
// Optional statistics counters are built only with OUT_PACKER_STATS_EN.
module merge_out_packer #(
  parameter int DATA_WIDTH = 128
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic [8*DATA_WIDTH-1:0] i_data,
  input  logic                    i_write,
  output logic                    o_ready,
  output logic [4*DATA_WIDTH-1:0] o_data,
  output logic                    o_valid,
  input  logic                    i_ready,
  output logic                    o_run_done,
  output logic                    o_overflow,
  output logic [31:0]             o_rec_count,
  output logic [31:0]             o_stall_count
);

  localparam int BW = 8 * DATA_WIDTH;
  localparam int HW = 4 * DATA_WIDTH;

  logic [BW-1:0] mem_q [2];
  logic          wr_ptr_q, wr_ptr_d;
  logic          rd_ptr_q, rd_ptr_d;
  logic [1:0]    cnt_q, cnt_d;
  logic          half_q, half_d;
  logic          done_q, done_d;
  logic          ovf_q, ovf_d;

  logic [BW-1:0] head;
  logic          xfer;
  logic          pop;
  logic          push;
  logic [3:0]    nz;
  logic          term;

  assign head       = mem_q[rd_ptr_q];
  assign o_data     = half_q ? head[BW-1:HW] : head[HW-1:0];
  assign o_valid    = (cnt_q != 2'd0);
  assign xfer       = o_valid & i_ready;
  assign pop        = xfer & half_q;
  assign o_ready    = (cnt_q != 2'd2) | pop;
  assign push       = i_write & o_ready;
  assign o_run_done = done_q;
  assign o_overflow = ovf_q;

  // Flag which of the four presented records are non-terminal.
  always_comb begin
    nz = '0;
    for (int k = 0; k < 4; k++) begin
      nz[k] = |o_data[k*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign term = ~&nz;

  // Next-state for FIFO pointers, occupancy, half pointer and flags.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    half_d   = half_q;
    done_d   = xfer & term;
    ovf_d    = ovf_q | (i_write & ~o_ready);
    if (push) wr_ptr_d = ~wr_ptr_q;
    if (pop)  rd_ptr_d = ~rd_ptr_q;
    if (xfer) half_d = ~half_q;
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  // Control state register; buffered data is dropped on reset.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
      half_q   <= 1'b0;
      done_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      half_q   <= half_d;
      done_q   <= done_d;
      ovf_q    <= ovf_d;
    end
  end

  // Beat storage; contents are only meaningful while counted valid.
  always_ff @(posedge i_clk) begin
    if (push) mem_q[wr_ptr_q] <= i_data;
  end

`ifdef OUT_PACKER_STATS_EN
  logic [31:0] rec_q, rec_d;
  logic [31:0] stall_q, stall_d;
  logic [2:0]  n_nt;
  logic [32:0] rec_sum;

  // Saturating record and stall counters; a terminal transfer restarts the run.
  always_comb begin
    n_nt = 3'd0;
    for (int k = 0; k < 4; k++) begin
      n_nt = n_nt + {2'b00, nz[k]};
    end
    rec_sum = {1'b0, rec_q} + {30'd0, n_nt};
    rec_d   = rec_q;
    stall_d = stall_q;
    if (xfer) begin
      if (term)             rec_d = '0;
      else if (rec_sum[32]) rec_d = '1;
      else                  rec_d = rec_sum[31:0];
    end
    if (o_valid && !i_ready && !(&stall_q)) begin
      stall_d = stall_q + 32'd1;
    end
  end

  // Counter registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rec_q   <= '0;
      stall_q <= '0;
    end else begin
      rec_q   <= rec_d;
      stall_q <= stall_d;
    end
  end

  assign o_rec_count   = rec_q;
  assign o_stall_count = stall_q;
`else
  assign o_rec_count   = '0;
  assign o_stall_count = '0;
`endif

endmodule
